// File: rtl/bp_me_pkg.sv
// Shared types and field helpers for the wormhole memory-command arbiter.
package bp_me_pkg;

  typedef enum logic {
    e_arb_idle = 1'b0,
    e_arb_send = 1'b1
  } bp_me_wh_arb_state_e;

  // The len field sits directly above the cord field in an encoded packet.
  function automatic int wh_len_offset(input int cord_width);
    return cord_width;
  endfunction

  function automatic int wh_len_width(input int len_width);
    return len_width;
  endfunction

  function automatic int wh_max_flits(input int pkt_width, input int flit_width);
    return (pkt_width + flit_width - 1) / flit_width;
  endfunction

endpackage

// File: rtl/bp_me_wormhole_mem_cmd_arb_if.sv
// Requester-side packet bus plus downstream flit link of the wormhole arbiter.
interface bp_me_wormhole_mem_cmd_arb_if #(
  parameter int num_req_p    = 2,
  parameter int flit_width_p = 64,
  parameter int pkt_width_p  = 640
);
  logic [num_req_p*pkt_width_p-1:0] pkt_i;
  logic [num_req_p-1:0]             pkt_v_i;
  logic [num_req_p-1:0]             pkt_ready_and_o;
  logic [flit_width_p-1:0]          link_data_o;
  logic                             link_v_o;
  logic                             link_ready_and_i;
  logic                             busy_o;

  modport slave (
    input  pkt_i, pkt_v_i, link_ready_and_i,
    output pkt_ready_and_o, link_data_o, link_v_o, busy_o
  );

  modport master (
    output pkt_i, pkt_v_i, link_ready_and_i,
    input  pkt_ready_and_o, link_data_o, link_v_o, busy_o
  );
endinterface

// File: rtl/bp_me_wormhole_rr_arb.sv
// Combinational grant with round-robin pointer register.
// Define BP_ME_WH_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority (no pointer).
module bp_me_wormhole_rr_arb
  import bp_me_pkg::*;
#(
  parameter int num_req_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  input  logic [num_req_p-1:0] v_i,
  output logic [num_req_p-1:0] grant_o
);

`ifdef BP_ME_WH_ARB_FIXED_PRIO_EN
  wire unused_clk_rst = ^{clk_i, reset_n_i};

  always_comb begin
    logic found;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (en_i && !found && v_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
      end
    end
  end
`else
  localparam int ptr_w_lp = $clog2(num_req_p);

  logic [ptr_w_lp-1:0] ptr_q, ptr_d;

  // Scan from the pointer, wrapping; pointer moves past the winner only on a grant.
  always_comb begin
    logic found;
    int   idx;
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int j = 0; j < num_req_p; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (en_i && !found && v_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = (idx == num_req_p - 1) ? '0 : ptr_w_lp'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/bp_me_wormhole_mem_cmd_arb.sv
// Arbitrates whole encoded packets from num_req_p requesters onto one wormhole link,
// LSB flit first. Define BP_ME_WH_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module bp_me_wormhole_mem_cmd_arb
  import bp_me_pkg::*;
#(
  parameter int num_req_p    = 2,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 7,
  parameter int len_width_p  = 4,
  parameter int pkt_width_p  = 640
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bp_me_wormhole_mem_cmd_arb_if.slave   bus
);

  localparam int max_flits_lp = wh_max_flits(pkt_width_p, flit_width_p);
  localparam int buf_w_lp     = max_flits_lp * flit_width_p;
  localparam int cnt_w_lp     = (max_flits_lp > 1) ? $clog2(max_flits_lp) : 1;
  localparam int len_lsb_lp   = wh_len_offset(cord_width_p);
  localparam int len_w_lp     = wh_len_width(len_width_p);

  bp_me_wh_arb_state_e state_q, state_d;
  logic [cnt_w_lp-1:0] k_q, k_d, last_q, last_d;
  logic [max_flits_lp-1:0][flit_width_p-1:0] buf_q;

  logic [num_req_p-1:0]   grant;
  logic [pkt_width_p-1:0] sel_pkt;
  logic [len_w_lp-1:0]    len_raw;
  logic                   accept, flit_hs, sending;

  bp_me_wormhole_rr_arb #(.num_req_p(num_req_p)) arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (reset_n_i && (state_q == e_arb_idle)),
    .v_i       (bus.pkt_v_i),
    .grant_o   (grant)
  );

  // Grants are only ever issued to valid requesters, so any grant is an accept.
  assign accept  = |grant;
  assign sending = reset_n_i && (state_q == e_arb_send);
  assign flit_hs = sending && bus.link_ready_and_i;

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < num_req_p; i++)
      if (grant[i]) sel_pkt = sel_pkt | bus.pkt_i[i*pkt_width_p +: pkt_width_p];
  end

  assign len_raw = sel_pkt[len_lsb_lp +: len_w_lp];

  // Oversized len values are clamped to the buffer depth.
  always_comb begin
    if (int'(len_raw) > max_flits_lp - 1) last_d = cnt_w_lp'(max_flits_lp - 1);
    else                                  last_d = cnt_w_lp'(len_raw);
  end

  always_comb begin
    k_d = k_q;
    if (accept)       k_d = '0;
    else if (flit_hs) k_d = (k_q == last_q) ? '0 : k_q + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_arb_idle;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_q  <= buf_w_lp'(sel_pkt);
      last_q <= last_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_arb_idle: if (accept) state_d = e_arb_send;
      e_arb_send: if (flit_hs && (k_q == last_q)) state_d = e_arb_idle;
      default:    state_d = e_arb_idle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.pkt_ready_and_o = grant;
    bus.link_v_o        = sending;
    bus.busy_o          = sending;
    bus.link_data_o     = sending ? buf_q[k_q] : '0;
  end

endmodule
